// File: rtl/pid_math_mc.sv
// Time-multiplexed PD/PID error math: one vld snapshots all channels, one channel computed per clock.
// Optional integral term enabled by defining PID_MATH_ITERM_EN.
`timescale 1ns/1ps

module pid_math_mc #(
    parameter int         NCH     = 3,
    parameter int         ERR_W   = 10,
    parameter int         D_DEPTH = 12,
    parameter logic [4:0] DGAIN   = 5'd7,
    localparam int        CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld,
    input  logic [16*NCH-1:0]    desired,
    input  logic [16*NCH-1:0]    actual,
    input  logic                 clr_hist,
    output logic                 busy,
    output logic                 ovr,
    output logic                 out_vld,
    output logic [CW-1:0]        out_ch,
    output logic [ERR_W-1:0]     pterm,
    output logic [11:0]          dterm,
    output logic [ERR_W-1:0]     iterm
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    localparam int            EMAX    = 2**(ERR_W-1) - 1;
    localparam int            EMIN    = -(2**(ERR_W-1));
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    state_t                    state_q, state_d;
    logic [CW-1:0]             ch_q, ch_d;
    logic [16*NCH-1:0]         des_q, des_d;
    logic [16*NCH-1:0]         act_q, act_d;
    logic signed [ERR_W-1:0]   hist_q [NCH][D_DEPTH];
    logic signed [ERR_W-1:0]   hist_d [NCH][D_DEPTH];
    logic                      out_vld_q, out_vld_d;
    logic                      ovr_q, ovr_d;
    logic [CW-1:0]             out_ch_q, out_ch_d;
    logic signed [ERR_W-1:0]   pterm_q, pterm_d;
    logic signed [11:0]        dterm_q, dterm_d;

    logic signed [15:0]        des_s, act_s;
    logic signed [31:0]        err_w, diff_w;
    logic signed [ERR_W-1:0]   err_sat, tail, pterm_c;
    logic signed [6:0]         dsat;
    logic signed [11:0]        gain_x, dsat_x, dterm_c;

`ifdef PID_MATH_ITERM_EN
    localparam int             AMAX = 2**(ERR_W+5) - 1;
    localparam int             AMIN = -(2**(ERR_W+5));
    logic signed [ERR_W+5:0]   acc_q [NCH];
    logic signed [ERR_W+5:0]   acc_d [NCH];
    logic signed [ERR_W+5:0]   acc_cur, acc_new;
    logic signed [31:0]        acc_w;
    logic signed [ERR_W-1:0]   iterm_c, iterm_q, iterm_d;
`endif

    // Datapath for the channel currently selected by ch_q.
    always_comb begin
        des_s = '0;
        act_s = '0;
        tail  = '0;
`ifdef PID_MATH_ITERM_EN
        acc_cur = '0;
`endif
        for (int unsigned c = 0; c < NCH; c++) begin
            if (CW'(c) == ch_q) begin
                des_s = des_q[16*c +: 16];
                act_s = act_q[16*c +: 16];
                tail  = hist_q[c][D_DEPTH-1];
`ifdef PID_MATH_ITERM_EN
                acc_cur = acc_q[c];
`endif
            end
        end

        err_w = 32'(act_s) - 32'(des_s);
        if (err_w > EMAX) begin
            err_sat = ERR_W'(EMAX);
        end else if (err_w < EMIN) begin
            err_sat = ERR_W'(EMIN);
        end else begin
            err_sat = ERR_W'(err_w);
        end

        pterm_c = (err_sat >>> 1) + (err_sat >>> 3);

        diff_w = 32'(err_sat) - 32'(tail);
        if (diff_w > 63) begin
            dsat = 7'h3F;
        end else if (diff_w < -64) begin
            dsat = 7'h40;
        end else begin
            dsat = 7'(diff_w);
        end

        // Gain is an unsigned 5-bit constant, zero-extended before the signed multiply.
        gain_x  = {7'd0, DGAIN};
        dsat_x  = {{5{dsat[6]}}, dsat};
        dterm_c = gain_x * dsat_x;

`ifdef PID_MATH_ITERM_EN
        acc_w = 32'(acc_cur) + 32'(err_sat);
        if (acc_w > AMAX) begin
            acc_new = (ERR_W+6)'(AMAX);
        end else if (acc_w < AMIN) begin
            acc_new = (ERR_W+6)'(AMIN);
        end else begin
            acc_new = (ERR_W+6)'(acc_w);
        end
        iterm_c = ERR_W'(acc_new >>> 6);
`endif
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        des_d     = des_q;
        act_d     = act_q;
        hist_d    = hist_q;
        out_vld_d = 1'b0;
        ovr_d     = 1'b0;
        out_ch_d  = out_ch_q;
        pterm_d   = pterm_q;
        dterm_d   = dterm_q;
`ifdef PID_MATH_ITERM_EN
        acc_d     = acc_q;
        iterm_d   = iterm_q;
`endif

        if (clr_hist) begin
            state_d = IDLE;
            ch_d    = '0;
            hist_d  = '{default: '0};
`ifdef PID_MATH_ITERM_EN
            acc_d   = '{default: '0};
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld) begin
                        des_d   = desired;
                        act_d   = actual;
                        ch_d    = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    out_vld_d = 1'b1;
                    out_ch_d  = ch_q;
                    pterm_d   = pterm_c;
                    dterm_d   = dterm_c;
`ifdef PID_MATH_ITERM_EN
                    iterm_d   = iterm_c;
`endif
                    for (int unsigned c = 0; c < NCH; c++) begin
                        if (CW'(c) == ch_q) begin
                            for (int unsigned i = 1; i < D_DEPTH; i++) begin
                                hist_d[c][i] = hist_q[c][i-1];
                            end
                            hist_d[c][0] = err_sat;
`ifdef PID_MATH_ITERM_EN
                            acc_d[c] = acc_new;
`endif
                        end
                    end
                    if (vld) begin
                        ovr_d = 1'b1;
                    end
                    if (ch_q == LAST_CH) begin
                        ch_d    = '0;
                        state_d = IDLE;
                    end else begin
                        ch_d = ch_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            des_q     <= '0;
            act_q     <= '0;
            hist_q    <= '{default: '0};
            out_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
            out_ch_q  <= '0;
            pterm_q   <= '0;
            dterm_q   <= '0;
`ifdef PID_MATH_ITERM_EN
            acc_q     <= '{default: '0};
            iterm_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            des_q     <= des_d;
            act_q     <= act_d;
            hist_q    <= hist_d;
            out_vld_q <= out_vld_d;
            ovr_q     <= ovr_d;
            out_ch_q  <= out_ch_d;
            pterm_q   <= pterm_d;
            dterm_q   <= dterm_d;
`ifdef PID_MATH_ITERM_EN
            acc_q     <= acc_d;
            iterm_q   <= iterm_d;
`endif
        end
    end

    assign busy    = (state_q == CALC);
    assign ovr     = ovr_q;
    assign out_vld = out_vld_q;
    assign out_ch  = out_ch_q;
    assign pterm   = pterm_q;
    assign dterm   = dterm_q;
`ifdef PID_MATH_ITERM_EN
    assign iterm   = iterm_q;
`else
    assign iterm   = '0;
`endif

endmodule

// File: tb/tb_pid_math_mc.sv
// Directed bench for pid_math_mc (NCH=3, ERR_W=10, D_DEPTH=12, DGAIN=7).
`timescale 1ns/1ps

module tb_pid_math_mc;

    logic        clk = 1'b0;
    logic        rst_n, vld, clr_hist;
    logic [47:0] desired, actual;
    logic        busy, ovr, out_vld;
    logic [1:0]  out_ch;
    logic [9:0]  pterm, iterm;
    logic [11:0] dterm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pid_math_mc #(
        .NCH(3),
        .ERR_W(10),
        .D_DEPTH(12),
        .DGAIN(5'd7)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vld(vld),
        .desired(desired),
        .actual(actual),
        .clr_hist(clr_hist),
        .busy(busy),
        .ovr(ovr),
        .out_vld(out_vld),
        .out_ch(out_ch),
        .pterm(pterm),
        .dterm(dterm),
        .iterm(iterm)
    );

    typedef struct {
        logic [2:0][15:0] des;
        logic [2:0][15:0] act;
        logic [2:0][11:0] p;
        logic [2:0][11:0] d;
        logic [2:0][11:0] it;
        bit               chk_i;
    } vec_t;

    function automatic vec_t mk(input int d0, input int d1, input int d2,
                                input int a0, input int a1, input int a2,
                                input int p0, input int p1, input int p2,
                                input int e0, input int e1, input int e2);
        vec_t v;
        v.des[0] = 16'(d0); v.des[1] = 16'(d1); v.des[2] = 16'(d2);
        v.act[0] = 16'(a0); v.act[1] = 16'(a1); v.act[2] = 16'(a2);
        v.p[0]   = 12'(p0); v.p[1]   = 12'(p1); v.p[2]   = 12'(p2);
        v.d[0]   = 12'(e0); v.d[1]   = 12'(e1); v.d[2]   = 12'(e2);
        v.it     = '0;
        v.chk_i  = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic expect_res(input int ch, input int p, input int d, input int it, input bit chk_i);
        chk($sformatf("ch%0d out_vld", ch), int'(out_vld), 1);
        chk($sformatf("ch%0d out_ch", ch), int'(out_ch), ch);
        chk($sformatf("ch%0d pterm", ch), int'($signed(pterm)), p);
        chk($sformatf("ch%0d dterm", ch), int'($signed(dterm)), d);
`ifdef PID_MATH_ITERM_EN
        if (chk_i) chk($sformatf("ch%0d iterm", ch), int'($signed(iterm)), it);
`else
        chk($sformatf("ch%0d iterm", ch), int'(iterm), 0);
`endif
    endtask

    task automatic run_set(input vec_t v);
        desired = v.des;
        actual  = v.act;
        vld     = 1'b1;
        tick();
        vld = 1'b0;
        chk("busy after vld", int'(busy), 1);
        chk("no result before ch0", int'(out_vld), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_res(k, int'($signed(v.p[k])), int'($signed(v.d[k])),
                       int'($signed(v.it[k])), v.chk_i);
            chk("ovr quiet", int'(ovr), 0);
        end
        chk("busy after last ch", int'(busy), 0);
    endtask

    task automatic pulse_clr();
        clr_hist = 1'b1;
        tick();
        clr_hist = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        vec_t v, va;

        tbl[0] = mk(0, 0, 0,            'h0100, 0, 0,           160, 0, 0,       441, 0, 0);
        tbl[1] = mk('h8000, 'h7FFF, 0,  'h7FFF, 'h8000, 5,      318, -320, 2,    441, -448, 35);
        tbl[2] = mk(0, 40, 'h0040,      -3, 100, 0,             -3, 37, -40,     -21, 420, -448);
        tbl[3] = mk(0, 'h0200, 0,       'h01FF, 0, 'h0200,      318, -320, 318,  441, -448, 441);
        tbl[4] = mk('h0FC1, 'hFF00, 0,  'h1000, 'hFE00, 1,      38, -160, 0,     441, -448, 7);
        tbl[5] = mk(0, 0, 'hFFFF,       -1, 0, 'h7FFF,          -2, 0, 318,      -7, 0, 441);

        rst_n = 1'b0; vld = 1'b0; clr_hist = 1'b0; desired = '0; actual = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst out_vld", int'(out_vld), 0);
        chk("rst pterm", int'(pterm), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle busy", int'(busy), 0);
        chk("idle ovr", int'(ovr), 0);
        chk("idle out_vld", int'(out_vld), 0);
        chk("idle out_ch", int'(out_ch), 0);
        chk("idle pterm", int'(pterm), 0);
        chk("idle dterm", int'(dterm), 0);
        chk("idle iterm", int'(iterm), 0);

        // Fewer than D_DEPTH samples per channel: every dterm is against zero history.
        for (int i = 0; i < 6; i++) run_set(tbl[i]);

        // Constant error: ch1 +20, ch0 -20, 13 samples after clearing.
        pulse_clr();
        for (int s = 1; s <= 13; s++) begin
            v = mk(20, 0, 0, 0, 20, 0, -13, 12, 0,
                   (s <= 12) ? -140 : 0, (s <= 12) ? 140 : 0, 0);
            run_set(v);
        end

        // Reset in the middle of a sequence.
        v = mk(20, 0, 0, 0, 20, 0, -13, 12, 0, -140, 140, 0);
        desired = v.des; actual = v.act; vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("async rst busy", int'(busy), 0);
        chk("async rst out_vld", int'(out_vld), 0);
        chk("async rst pterm", int'(pterm), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_set(v);

        // vld while busy: ovr pulse, snapshot unaffected by later input changes.
        pulse_clr();
        va = mk(0, 0, 0, 'h0100, 0, 0, 160, 0, 0, 441, 0, 0);
        desired = va.des; actual = va.act; vld = 1'b1;
        tick();
        desired = '0;
        actual  = {3{16'h0050}};
        chk("busy in calc", int'(busy), 1);
        tick();
        vld = 1'b0;
        chk("ovr pulse", int'(ovr), 1);
        expect_res(0, 160, 441, 0, 1'b0);
        tick();
        chk("ovr one cycle", int'(ovr), 0);
        expect_res(1, 0, 0, 0, 1'b0);
        tick();
        expect_res(2, 0, 0, 0, 1'b0);
        chk("busy end ovr seq", int'(busy), 0);
        tick();
        chk("only three results", int'(out_vld), 0);

        // Fill ch0 history to depth, then clear mid-sequence.
        for (int s = 2; s <= 12; s++) run_set(va);
        desired = va.des; actual = va.act; vld = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        expect_res(0, 160, 0, 0, 1'b0);
        clr_hist = 1'b1;
        vld = 1'b1;
        tick();
        clr_hist = 1'b0;
        vld = 1'b0;
        chk("clr busy", int'(busy), 0);
        chk("clr out_vld", int'(out_vld), 0);
        chk("clr no ovr", int'(ovr), 0);
        chk("clr pterm hold", int'($signed(pterm)), 160);
        tick();
        chk("clr vld dropped busy", int'(busy), 0);
        chk("clr vld dropped out_vld", int'(out_vld), 0);
        run_set(va);

        // Integral ramp on ch2 (stays 0 without the integral feature).
        pulse_clr();
        for (int s = 1; s <= 4; s++) begin
            v = mk(0, 0, 0, 0, 0, 64, 0, 0, 40, 0, 0, 441);
            v.it[2] = 12'(s);
            v.chk_i = 1'b1;
            run_set(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
